// File: rtl/gen_reg_if.sv
// ----------------------------------------------------------------------------
// gen_reg_if
// Signal bundle for connecting to a gen_reg instance. The register keeps its
// plain positional port list (clk, rst, din, dout, wen, ...) so that existing
// instances stay compatible. This bundle groups the data/control side for
// harnesses and for users that prefer a single connection point.
//
// Parameters:
//   WIDTH     data width in bits
// Signals:
//   din       write data                       (master -> slave)
//   wen       write enable                     (master -> slave)
//   wmask     per-bit write mask, 1 = written  (master -> slave)
//   dout      registered value                 (slave -> master)
//   dout_nxt  value dout takes at next edge    (slave -> master)
//   upd       one-cycle flag, dout changed     (slave -> master)
//   par_err   stored-state parity mismatch     (slave -> master)
// Modports:
//   master    drives din/wen/wmask, observes the register outputs
//   slave     the register side
// ----------------------------------------------------------------------------
interface gen_reg_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] din;
    logic             wen;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dout_nxt;
    logic             upd;
    logic             par_err;

    modport master (
        output din, wen, wmask,
        input  dout, dout_nxt, upd, par_err
    );

    modport slave (
        input  din, wen, wmask,
        output dout, dout_nxt, upd, par_err
    );
endinterface

// File: rtl/gen_reg.sv
// ----------------------------------------------------------------------------
// gen_reg
// Generic WIDTH-bit state register with write enable, per-bit write mask and
// a registered "value changed" flag. Used as the IFU PC register with
// WIDTH=64, RESET_VAL=32'h80000000, wen tied high and next_pc on din.
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   RESET_VAL  value loaded on reset, zero-extended/truncated to WIDTH
// Ports (first five are positional-order sensitive):
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (0 = reset)
//   din       in   write data
//   dout      out  registered value
//   wen       in   write enable
//   wmask     in   per-bit write mask, 1 = bit written
//   dout_nxt  out  combinational value dout takes at the next rising edge
//   upd       out  registered, 1 for one cycle after an edge where dout changed
//   par_err   out  parity mismatch on stored state
// Optional feature:
//   GEN_REG_PARITY_EN  when defined, a parity bit is stored alongside dout
//                      and par_err flags corruption of the stored value;
//                      when undefined, par_err is constant 0.
// ----------------------------------------------------------------------------
module gen_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen,
    input  logic [WIDTH-1:0] wmask,
    output logic [WIDTH-1:0] dout_nxt,
    output logic             upd,
    output logic             par_err
);

    logic [WIDTH-1:0] dout_reg;
    logic             upd_reg;
    logic [WIDTH-1:0] merged;

    // Per-bit select rather than and/or masking: a masked-out bit takes the
    // stored value outright, so X/Z on din never leaks into those bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
        assign merged[gi] = wmask[gi] ? din[gi] : dout_reg[gi];
    end

    assign dout_nxt = wen ? merged : dout_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_reg <= RESET_VAL;
            upd_reg  <= 1'b0;
        end else begin
            dout_reg <= dout_nxt;
            upd_reg  <= (dout_nxt != dout_reg);
        end
    end

    assign dout = dout_reg;
    assign upd  = upd_reg;

`ifdef GEN_REG_PARITY_EN
    logic par_reg;

    // Parity follows every write; with wen=0 dout holds, so the stored bit
    // stays consistent without updating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_reg <= ^RESET_VAL;
        end else if (wen) begin
            par_reg <= ^dout_nxt;
        end
    end

    assign par_err = (^dout_reg) ^ par_reg;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_gen_reg.sv
// ----------------------------------------------------------------------------
// tb_gen_reg
// Self-checking bench for gen_reg (WIDTH=64, RESET_VAL=32'h80000000).
// A reference value of the register is kept in the bench and advanced from
// the masked-write rule; directed steps cover reset, PC-style increment,
// hold, masked writes, rewrite of the same value, reset during a write and
// parity, followed by a randomized stretch.
// ----------------------------------------------------------------------------
module tb_gen_reg;

    localparam int          W  = 64;
    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ONES = '1;

    logic clk;
    logic rst;

    gen_reg_if #(.WIDTH(W)) bus ();

    gen_reg #(
        .WIDTH     (W),
        .RESET_VAL (32'h8000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.din),
        .dout     (bus.dout),
        .wen      (bus.wen),
        .wmask    (bus.wmask),
        .dout_nxt (bus.dout_nxt),
        .upd      (bus.upd),
        .par_err  (bus.par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clocked transaction: drive at negedge, check the look-ahead value,
    // then check the captured value and change flag after the edge.
    task automatic step(input logic [63:0] d, input logic w, input logic [63:0] mk);
        logic [63:0] exp_nxt;
        logic        exp_upd;
        @(negedge clk);
        bus.din   = d;
        bus.wen   = w;
        bus.wmask = mk;
        #1;
        exp_nxt = model;
        if (w) begin
            for (int b = 0; b < W; b++)
                if (mk[b] === 1'b1) exp_nxt[b] = d[b];
        end
        check("dout_nxt", bus.dout_nxt, exp_nxt);
        @(posedge clk);
        #1;
        exp_upd = (exp_nxt !== model);
        model   = exp_nxt;
        check("dout", bus.dout, model);
        check("upd", {63'd0, bus.upd}, {63'd0, exp_upd});
        check("par_err", {63'd0, bus.par_err}, 64'd0);
        $display("step din=%h wen=%0b wmask=%h dout=%h upd=%0b",
                 d, w, mk, bus.dout, bus.upd);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] rm;
        logic        rw;
        logic [63:0] flipped;

        rst       = 1'b1;
        bus.din   = '0;
        bus.wen   = 1'b0;
        bus.wmask = ONES;

        // Asynchronous reset asserted mid-cycle, before any clock edge.
        #3 rst = 1'b0;
        #1;
        check("rst_dout", bus.dout, RV);
        check("rst_upd", {63'd0, bus.upd}, 64'd0);
        check("rst_par", {63'd0, bus.par_err}, 64'd0);
        $display("reset dout=%h upd=%0b", bus.dout, bus.upd);

        // Release mid-cycle.
        @(negedge clk);
        #2 rst = 1'b1;
        model = RV;

        // PC-style increment with full mask.
        step(model + 64'd4, 1'b1, ONES);
        check("pc_4", bus.dout, 64'h8000_0004);
        step(model + 64'd4, 1'b1, ONES);
        check("pc_8", bus.dout, 64'h8000_0008);

        // Hold with wen=0.
        step(64'hDEAD, 1'b0, ONES);
        check("hold", bus.dout, 64'h8000_0008);

        // Masked write.
        step(64'hFFFF_0000, 1'b1, ONES);
        step(64'h1234_5678, 1'b1, 64'h0000_FF00);
        check("mask_ff00", bus.dout, 64'hFFFF_5600);

        // wmask=0 holds; X on masked-out bits must not reach outputs.
        step(64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 64'd0);
        step('x, 1'b1, 64'd0);
        step('x, 1'b0, ONES);
        check("x_hold", bus.dout, 64'hFFFF_5600);

        // Rewrite the same value: no change flag.
        step(model, 1'b1, ONES);

        // Reset asserted in the middle of a write, before the edge.
        @(negedge clk);
        bus.din   = 64'h0123_4567_89AB_CDEF;
        bus.wen   = 1'b1;
        bus.wmask = ONES;
        #2 rst = 1'b0;
        #1;
        check("midw_dout", bus.dout, RV);
        check("midw_upd", {63'd0, bus.upd}, 64'd0);
        $display("midwrite reset dout=%h upd=%0b", bus.dout, bus.upd);
        bus.wen = 1'b0;
        #1 rst = 1'b1;
        model = RV;
        step(64'h0123_4567_89AB_CDEF, 1'b1, ONES);

`ifdef GEN_REG_PARITY_EN
        // Corrupt one stored bit; parity must flag it until the next write.
        @(negedge clk);
        bus.wen = 1'b0;
        flipped = model ^ 64'h8;
        force dut.dout_reg = flipped;
        #1 release dut.dout_reg;
        #1;
        check("par_flip", {63'd0, bus.par_err}, 64'd1);
        $display("parity flip dout=%h par_err=%0b", bus.dout, bus.par_err);
        model = flipped;
        step(64'h5555_0000_AAAA_1111, 1'b1, ONES);
`else
        flipped = model;
        check("par_off", {63'd0, bus.par_err}, 64'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            rd = {$urandom, $urandom};
            rw = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rm = ONES;
                1:       rm = 64'd0;
                default: rm = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) rd = model;
            step(rd, rw, rm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
